// File: rtl/holo_pkg.sv
// rtl/holo_pkg.sv - shared carrier, channel and phase constants and types
package holo_pkg;

  localparam int CLK_FREQ     = 10_240_000;
  localparam int OUT_FREQ     = 40_000;
  localparam int NUM_CHANNELS = 2;
  localparam int PERIOD       = CLK_FREQ / OUT_FREQ;
  localparam int PHASE_W      = $clog2(PERIOD);

  typedef logic [PHASE_W-1:0] phase_t;
  typedef phase_t phase_bank_t [NUM_CHANNELS];

endpackage

// File: rtl/sync_detect.sv
// rtl/sync_detect.sv - sync_in synchronizer, rising-edge detect and loss timeout
module sync_detect #(
  parameter int PERIOD = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sync_in,
  input  logic clear,
  output logic sync_edge,
  output logic sync_lost
);

  localparam int LIMIT = 2 * PERIOD;
  localparam int TW    = $clog2(LIMIT + 1);

  // [0] and [1] form the synchronizer, [2] holds the previous synchronized level
  logic [2:0]    sh_q, sh_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          lost_q, lost_d;

  always_comb begin
    sh_d      = {sh_q[1:0], sync_in};
    sync_edge = sh_q[1] & ~sh_q[2];
    timer_d   = timer_q;
    lost_d    = lost_q;
    if (sync_edge) begin
      timer_d = '0;
      lost_d  = 1'b0;
    end else begin
      // timer saturates so loss is flagged once per silence, letting clear stick
      if (timer_q != TW'(LIMIT)) timer_d = timer_q + 1'b1;
      if (timer_q == TW'(LIMIT - 1)) lost_d = 1'b1;
      else if (clear)                lost_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q    <= '0;
      timer_q <= '0;
      lost_q  <= 1'b0;
    end else begin
      sh_q    <= sh_d;
      timer_q <= timer_d;
      lost_q  <= lost_d;
    end
  end

  assign sync_lost = lost_q;

endmodule

// File: rtl/phase_scheduler.sv
// rtl/phase_scheduler.sv - shadow/active phase banks, period counter and drive; SYNC_MASTER_EN selects master build
module phase_scheduler
  import holo_pkg::*;
#(
  parameter int CLK_FREQ     = holo_pkg::CLK_FREQ,
  parameter int OUT_FREQ     = holo_pkg::OUT_FREQ,
  parameter int NUM_CHANNELS = holo_pkg::NUM_CHANNELS,
  parameter int PERIOD       = CLK_FREQ / OUT_FREQ,
  parameter int PHASE_W      = $clog2(PERIOD),
  parameter int SYNC_W       = 4,
  parameter int SYNC_COMP    = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [PHASE_W-1:0]      phases_in [NUM_CHANNELS],
  input  logic                    phases_valid,
  input  logic                    out_en,
  input  logic                    clear_status,
  input  logic                    sync_in,
  output logic                    sync_out,
  output logic [NUM_CHANNELS-1:0] trans,
  output logic [PHASE_W-1:0]      phases_active [NUM_CHANNELS],
  output logic [PHASE_W-1:0]      period_cnt,
  output logic                    commit,
  output logic                    pending,
  output logic                    overrun,
  output logic                    sync_lost
);

  if (PERIOD < 2 || (PERIOD & (PERIOD - 1)) != 0) begin : g_period_check
    $error("phase_scheduler: PERIOD must be a power of two");
  end

  logic [PHASE_W-1:0]      cnt_q, cnt_d;
  logic [PHASE_W-1:0]      shadow_q [NUM_CHANNELS];
  logic [PHASE_W-1:0]      shadow_d [NUM_CHANNELS];
  logic [PHASE_W-1:0]      active_q [NUM_CHANNELS];
  logic [PHASE_W-1:0]      active_d [NUM_CHANNELS];
  logic [PHASE_W-1:0]      diff     [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] trans_q, trans_d;
  logic                    pending_q, pending_d;
  logic                    overrun_q, overrun_d;
  logic                    commit_q, commit_d;
  logic                    sync_edge;
  logic                    boundary;

`ifdef SYNC_MASTER_EN
  logic [32:0] unused_cfg;
  assign unused_cfg = {sync_in, 32'(SYNC_COMP)};
  assign sync_edge  = 1'b0;
  assign sync_lost  = 1'b0;
  assign sync_out   = (cnt_q < PHASE_W'(SYNC_W));
`else
  logic [31:0] unused_cfg;
  assign unused_cfg = 32'(SYNC_W);
  assign sync_out   = 1'b0;

  sync_detect #(
    .PERIOD(PERIOD)
  ) u_sync_detect (
    .clk      (clk),
    .rst_n    (rst_n),
    .sync_in  (sync_in),
    .clear    (clear_status),
    .sync_edge(sync_edge),
    .sync_lost(sync_lost)
  );
`endif

  always_comb begin
    boundary  = sync_edge | (cnt_q == PHASE_W'(PERIOD - 1));
    cnt_d     = sync_edge ? PHASE_W'(SYNC_COMP) : cnt_q + 1'b1;
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    commit_d  = 1'b0;

    // commit reads the pre-edge shadow, so a same-cycle strobe waits a full period
    if (boundary && pending_q) begin
      active_d  = shadow_q;
      commit_d  = 1'b1;
      pending_d = 1'b0;
    end
    if (phases_valid) begin
      shadow_d  = phases_in;
      pending_d = 1'b1;
    end
    if (phases_valid && pending_q) overrun_d = 1'b0 | 1'b1;
    else if (clear_status)         overrun_d = 1'b0;

    // with PERIOD a power of two, d < PERIOD/2 is simply a clear MSB
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      diff[i]    = cnt_q - active_q[i];
      trans_d[i] = out_en & ~diff[i][PHASE_W-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      shadow_q  <= '{default: '0};
      active_q  <= '{default: '0};
      trans_q   <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      commit_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      trans_q   <= trans_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      commit_q  <= commit_d;
    end
  end

  assign trans         = trans_q;
  assign phases_active = active_q;
  assign period_cnt    = cnt_q;
  assign commit        = commit_q;
  assign pending       = pending_q;
  assign overrun       = overrun_q;

endmodule
